axi_tdd_ng_profile_seq: RTL

Frame-profile sequencer placed between the TDD register map and the TDD counter. It holds a small table of frame profiles (frame length, frame count). It drives tdd_enable, tdd_frame_length, tdd_burst_count and tdd_startup_delay into the counter. It steps through profiles 0..seq_last by counting counter end-of-frame pulses, which allows multi-pattern frame schedules without software rewrites between frames.

---
 rtl/axi_tdd_ng_pkg.sv | 16 +
 rtl/axi_tdd_ng_profile_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_ng_pkg.sv
// rtl/axi_tdd_ng_pkg.sv - shared types for the TDD frame-profile sequencer
//
// Contents:
//   seq_state_t : sequencer FSM states (IDLE, LOAD, SYNC, RUN, STOP)

package axi_tdd_ng_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_LOAD = 3'd1,
    SEQ_SYNC = 3'd2,
    SEQ_RUN  = 3'd3,
    SEQ_STOP = 3'd4
  } seq_state_t;

endpackage

// File: rtl/axi_tdd_ng_profile_seq.sv
// rtl/axi_tdd_ng_profile_seq.sv - frame-profile sequencer feeding the TDD counter
//
// Ports:
//   clk, rst                : TDD clock, synchronous active-high reset
//   cfg_wr/addr/...         : profile table write (length, frame count, startup delay)
//   seq_last, seq_loop      : last profile index of the schedule, wrap-around enable
//   seq_start, seq_stop     : start pulse, graceful-stop pulse
//   tdd_endof_frame         : end-of-frame pulse from the counter
//   tdd_enable/sync_soft    : counter enable and one-cycle soft sync
//   tdd_frame_length/...    : active frame parameters driven into the counter
//   seq_profile/busy/done   : active profile, busy flag, completion pulse
//   seq_error               : sticky, a zero frame count was encountered

module axi_tdd_ng_profile_seq
  import axi_tdd_ng_pkg::*;
#(
  parameter int PROFILE_COUNT     = 4,
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_wr,
  input  logic [$clog2(PROFILE_COUNT)-1:0] cfg_addr,
  input  logic [REGISTER_WIDTH-1:0]        cfg_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0]     cfg_frame_count,
  input  logic [REGISTER_WIDTH-1:0]        cfg_startup_delay,
  input  logic [$clog2(PROFILE_COUNT)-1:0] seq_last,
  input  logic                             seq_loop,
  input  logic                             seq_start,
  input  logic                             seq_stop,
  input  logic                             tdd_endof_frame,
  output logic                             tdd_enable,
  output logic                             tdd_sync_soft,
  output logic [REGISTER_WIDTH-1:0]        tdd_frame_length,
  output logic [BURST_COUNT_WIDTH-1:0]     tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]        tdd_startup_delay,
  output logic [$clog2(PROFILE_COUNT)-1:0] seq_profile,
  output logic                             seq_busy,
  output logic                             seq_done,
  output logic                             seq_error
);

  localparam int AW = $clog2(PROFILE_COUNT);
  localparam logic [AW-1:0] LAST_MAX = AW'(PROFILE_COUNT - 1);

  // Profile table: deliberately not reset, software reprograms it after reset.
  logic [REGISTER_WIDTH-1:0]    len_tbl [PROFILE_COUNT];
  logic [BURST_COUNT_WIDTH-1:0] cnt_tbl [PROFILE_COUNT];
  logic [REGISTER_WIDTH-1:0]    dly_tbl [PROFILE_COUNT];

  seq_state_t                   state, state_next;
  logic [BURST_COUNT_WIDTH-1:0] frame_cnt;
  logic [BURST_COUNT_WIDTH-1:0] act_cnt;
  logic                         stop_pending;

  logic [AW-1:0] last_c;
  logic [AW-1:0] prof_next;
  logic          load_first;
  logic          switch_prof;
  logic          cnt_inc;
  logic          set_err;
  logic          done_next;

  assign last_c    = (seq_last > LAST_MAX) ? LAST_MAX : seq_last;
  assign prof_next = (seq_profile == last_c) ? '0 : seq_profile + 1'b1;

  assign tdd_enable      = (state == SEQ_SYNC) || (state == SEQ_RUN);
  assign tdd_sync_soft   = (state == SEQ_SYNC);
  assign seq_busy        = (state != SEQ_IDLE);
  // The counter free-runs; frame counting is done here.
  assign tdd_burst_count = '0;

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      len_tbl[cfg_addr] <= cfg_frame_length;
      cnt_tbl[cfg_addr] <= cfg_frame_count;
      dly_tbl[cfg_addr] <= cfg_startup_delay;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_first  = 1'b0;
    switch_prof = 1'b0;
    cnt_inc     = 1'b0;
    set_err     = 1'b0;
    done_next   = 1'b0;
    case (state)
      SEQ_IDLE: begin
        // A coincident stop is simply not looked at here, so start wins.
        if (seq_start) begin
          state_next = SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        load_first = 1'b1;
        if (cnt_tbl[0] == '0) begin
          set_err    = 1'b1;
          done_next  = 1'b1;
          state_next = SEQ_IDLE;
        end else if (seq_stop) begin
          done_next  = 1'b1;
          state_next = SEQ_STOP;
        end else begin
          state_next = SEQ_SYNC;
        end
      end
      SEQ_SYNC: begin
        if (seq_stop) begin
          done_next  = 1'b1;
          state_next = SEQ_STOP;
        end else begin
          state_next = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (tdd_endof_frame) begin
          if (stop_pending || seq_stop) begin
            done_next  = 1'b1;
            state_next = SEQ_STOP;
          end else if (frame_cnt == act_cnt - 1'b1) begin
            if ((seq_profile == last_c) && !seq_loop) begin
              done_next  = 1'b1;
              state_next = SEQ_STOP;
            end else if (cnt_tbl[prof_next] == '0) begin
              set_err    = 1'b1;
              done_next  = 1'b1;
              state_next = SEQ_STOP;
            end else begin
              // Seamless switch: no resync, enable stays high.
              switch_prof = 1'b1;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      SEQ_STOP: begin
        state_next = SEQ_IDLE;
      end
      default: begin
        state_next = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt         <= '0;
      act_cnt           <= '0;
      stop_pending      <= 1'b0;
      tdd_frame_length  <= '0;
      tdd_startup_delay <= '0;
      seq_profile       <= '0;
      seq_done          <= 1'b0;
      seq_error         <= 1'b0;
    end else begin
      seq_done <= done_next;

      if (state_next != SEQ_RUN) begin
        stop_pending <= 1'b0;
      end else if (seq_stop) begin
        stop_pending <= 1'b1;
      end

      if ((state == SEQ_IDLE) && seq_start) begin
        seq_error <= 1'b0;
      end else if (set_err) begin
        seq_error <= 1'b1;
      end

      if (load_first) begin
        tdd_frame_length  <= len_tbl[0];
        tdd_startup_delay <= dly_tbl[0];
        act_cnt           <= cnt_tbl[0];
        seq_profile       <= '0;
        frame_cnt         <= '0;
      end else if (switch_prof) begin
        tdd_frame_length <= len_tbl[prof_next];
        act_cnt          <= cnt_tbl[prof_next];
        seq_profile      <= prof_next;
        frame_cnt        <= '0;
      end else if (cnt_inc) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
